// File: rtl/key_sched_ctrl_pkg.sv
// Shared constants, FSM state encoding and GF(2^8) helper for the AES-128 key schedule
// controller and its expansion datapath.
package key_sched_ctrl_pkg;

    localparam int unsigned NrRounds = 10;
    localparam int unsigned KeyWidth = 128;
    localparam int unsigned RndW     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } ks_state_e;

    // Multiply by x in GF(2^8), reducing by the AES polynomial on carry-out.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_sched_ctrl_round_key_buf.sv
// Round-key register file: one synchronous write port, one registered read port that
// returns zero when the read is not enabled or the address is out of range.
module key_sched_ctrl_round_key_buf #(
    parameter int unsigned Depth = 11,
    parameter int unsigned Width = 128,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = '0;
        if (re_i && (32'(raddr_i) < Depth)) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Storage is deliberately not reset; only the read register is cleared via re_i.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key schedule sequencer: latches the cipher key, requests one expansion per round
// from an external datapath, stores every round key and serves them by index once ready.
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
#(
    parameter int unsigned NR    = NrRounds,
    parameter int unsigned KEY_W = KeyWidth
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [KEY_W-1:0] KeyIn,
    output logic             ExpValid,
    output logic [KEY_W-1:0] PrevKey,
    output logic [7:0]       Rcon,
    input  logic             NextValid,
    input  logic [KEY_W-1:0] NextKey,
    input  logic [3:0]       RoundSel,
    output logic [KEY_W-1:0] RoundKey,
    output logic             ReadyKey,
    output logic             Busy
);

    ks_state_e        state_d, state_q;
    logic [RndW-1:0]  round_d, round_q;
    logic             exp_valid_d, exp_valid_q;
    logic [KEY_W-1:0] prev_key_d, prev_key_q;
    logic [7:0]       rcon_d, rcon_q;
    logic             ready_d, ready_q;
    logic             busy_d, busy_q;

    logic             wr_en;
    logic [RndW-1:0]  wr_addr;
    logic [KEY_W-1:0] wr_data;
    logic             rd_en;

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        exp_valid_d = 1'b0;
        prev_key_d  = prev_key_q;
        rcon_d      = rcon_q;
        wr_en       = 1'b0;
        wr_addr     = round_q;
        wr_data     = NextKey;

        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d     = StReq;
                    round_d     = RndW'(1);
                    exp_valid_d = 1'b1;
                    prev_key_d  = KeyIn;
                    rcon_d      = 8'h01;
                    wr_en       = 1'b1;
                    wr_addr     = '0;
                    wr_data     = KeyIn;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                if (NextValid) begin
                    wr_en      = 1'b1;
                    prev_key_d = NextKey;
                    if (round_q == RndW'(NR)) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StReq;
                        round_d     = round_q + RndW'(1);
                        exp_valid_d = 1'b1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StReq) || (state_d == StWait);
        // Ready one cycle after the last key lands; a restart in DONE drops it immediately.
        ready_d = (state_q == StDone) && (state_d == StDone);
        rd_en   = Rst && ready_d && (32'(RoundSel) <= NR);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= StIdle;
            round_q     <= '0;
            exp_valid_q <= 1'b0;
            prev_key_q  <= '0;
            rcon_q      <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            exp_valid_q <= exp_valid_d;
            prev_key_q  <= prev_key_d;
            rcon_q      <= rcon_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    key_sched_ctrl_round_key_buf #(
        .Depth (NR + 1),
        .Width (KEY_W),
        .AddrW (RndW)
    ) u_buf (
        .clk_i   (Clk),
        .we_i    (Rst && wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i (RoundSel),
        .rdata_o (RoundKey)
    );

    assign ExpValid = exp_valid_q;
    assign PrevKey  = prev_key_q;
    assign Rcon     = rcon_q;
    assign ReadyKey = ready_q;
    assign Busy     = busy_q;

endmodule
